// File: rtl/xor_sweep_ctrl.sv
// Exhaustive sweep controller for a pair of XOR implementations: steps every input vector,
// compares both results against a reduction-XOR golden value and reports mismatches.
module xor_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_res_a,
    input  logic            i_res_b,
    output logic [N_IN-1:0] o_vec_out,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_cnt,
    output logic [N_IN-1:0] o_first_err_vec,
    output logic            o_first_err_valid
);

    localparam int unsigned    WCW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WCW-1:0] WRELOAD  = WCW'(SETTLE - 1);
    localparam logic [N_IN:0]  ERR_MAX  = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StFin} state_e;

    state_e          r_state, w_state_nxt;
    logic [N_IN-1:0] r_vec, w_vec_nxt;
    logic [WCW-1:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_pass, w_pass_nxt;
    logic [N_IN:0]   r_err_cnt, w_err_cnt_nxt;
    logic [N_IN-1:0] r_first_vec, w_first_vec_nxt;
    logic            r_first_valid, w_first_valid_nxt;

    logic w_golden;
    logic w_mismatch;
    logic w_last;

    assign w_golden   = ^r_vec;
    assign w_mismatch = (i_res_a != w_golden) | (i_res_b != w_golden);
    assign w_last     = (r_vec == VEC_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_vec         <= '0;
            r_wait_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_cnt     <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_vec         <= w_vec_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_err_cnt     <= w_err_cnt_nxt;
            r_first_vec   <= w_first_vec_nxt;
            r_first_valid <= w_first_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (!i_abort && i_start) w_state_nxt = StWait;
            end
            StWait: begin
                if (i_abort)                 w_state_nxt = StIdle;
                else if (r_wait_cnt == '0)   w_state_nxt = StCheck;
            end
            StCheck: begin
                if (i_abort)     w_state_nxt = StIdle;
                else if (w_last) w_state_nxt = StFin;
                else             w_state_nxt = StWait;
            end
            StFin:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Registered outputs are computed one cycle ahead so done/pass/busy line up with FIN.
    always_comb begin
        w_vec_nxt         = r_vec;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_pass_nxt        = r_pass;
        w_err_cnt_nxt     = r_err_cnt;
        w_first_vec_nxt   = r_first_vec;
        w_first_valid_nxt = r_first_valid;

        case (r_state)
            StIdle: begin
                if (!i_abort && i_start) begin
                    w_err_cnt_nxt     = '0;
                    w_first_valid_nxt = 1'b0;
                    w_pass_nxt        = 1'b0;
                    w_vec_nxt         = '0;
                    w_wait_cnt_nxt    = WRELOAD;
                    w_busy_nxt        = 1'b1;
                end
            end
            StWait: begin
                if (!i_abort && r_wait_cnt != '0) w_wait_cnt_nxt = r_wait_cnt - 1'b1;
            end
            StCheck: begin
                if (!i_abort) begin
                    if (w_mismatch) begin
                        if (r_err_cnt != ERR_MAX) w_err_cnt_nxt = r_err_cnt + 1'b1;
                        if (!r_first_valid) begin
                            w_first_vec_nxt   = r_vec;
                            w_first_valid_nxt = 1'b1;
                        end
                    end
                    if (w_last) begin
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                        w_pass_nxt = (w_err_cnt_nxt == '0);
                    end else begin
                        w_vec_nxt      = r_vec + 1'b1;
                        w_wait_cnt_nxt = WRELOAD;
                    end
                end
            end
            default: ;
        endcase

        // Abort keeps partial error results but drops the sweep.
        if (i_abort && r_state != StIdle) begin
            w_busy_nxt = 1'b0;
            w_pass_nxt = 1'b0;
            w_vec_nxt  = '0;
        end
    end

    assign o_vec_out         = r_vec;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_err_cnt         = r_err_cnt;
    assign o_first_err_vec   = r_first_vec;
    assign o_first_err_valid = r_first_valid;

endmodule

// File: tb/tb_xor_sweep_ctrl.sv
// Scoreboard bench for xor_sweep_ctrl: expected sweep results are queued at start and
// checked by monitors when done pulses.
module tb_xor_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, start3;
    int         mode;
    logic [2:0] vec, fev, vec3, fev3;
    logic [3:0] ec, ec3;
    logic       busy, done, pass, fv, busy3, done3, pass3, fv3;
    logic       res_a, res_b, res_a3, res_b3;

    // Datapath models: 0 correct, 1 res_b stuck at 0, 2 res_a inverted
    always_comb begin
        res_a = ^vec;
        res_b = ^vec;
        case (mode)
            1:       res_b = 1'b0;
            2:       res_a = ~^vec;
            default: ;
        endcase
    end
    assign res_a3 = ^vec3;
    assign res_b3 = ^vec3;

    xor_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_res_a(res_a), .i_res_b(res_b), .o_vec_out(vec), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_err_cnt(ec), .o_first_err_vec(fev), .o_first_err_valid(fv)
    );

    xor_sweep_ctrl #(.N_IN(3), .SETTLE(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(1'b0),
        .i_res_a(res_a3), .i_res_b(res_b3), .o_vec_out(vec3), .o_busy(busy3), .o_done(done3),
        .o_pass(pass3), .o_err_cnt(ec3), .o_first_err_vec(fev3), .o_first_err_valid(fv3)
    );

    typedef struct {
        int         cyc;
        logic [3:0] ec;
        logic [2:0] fev;
        logic       fv;
        logic       pass;
    } exp_t;

    exp_t q[$];
    exp_t q3[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("err_cnt", int'(ec), int'(e.ec));
                chk("first_err_valid", int'(fv), int'(e.fv));
                chk("pass", int'(pass), int'(e.pass));
                chk("busy_at_done", int'(busy), 0);
                if (e.fv) chk("first_err_vec", int'(fev), int'(e.fev));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done3) begin
            total++;
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done3: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q3.pop_front();
                chk("done3_cycle", cyc, e.cyc);
                chk("err_cnt3", int'(ec3), int'(e.ec));
                chk("pass3", int'(pass3), int'(e.pass));
                chk("first_err_valid3", int'(fv3), int'(e.fv));
            end
        end
    end

    // Start edge is the posedge after this negedge; done shows 16 cycles later.
    task automatic go(input int m, input logic [3:0] e_ec, input logic [2:0] e_fev,
                      input logic e_fv, input logic e_pass);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        q.push_back('{cyc + 17, e_ec, e_fev, e_fv, e_pass});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && (q.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        total++;
        if (q.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL sweep_timeout: got %0d pending expected 0", q.size() + q3.size());
            q.delete();
            q3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vec(input logic [2:0] v);
        for (int i = 0; i < 100 && vec != v; i++) @(negedge clk);
        chk("reach_vec", int'(vec), int'(v));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"}, int'(vec), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_cnt"}, int'(ec), 0);
        chk({tag, "_first_vec"}, int'(fev), 0);
        chk({tag, "_first_valid"}, int'(fv), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sweep, vectors each held two cycles
        go(0, 4'd0, 3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk("vec_step", int'(vec), k / 2);
            chk("busy_sweep", int'(busy), 1);
            @(negedge clk);
        end
        wait_empty();
        chk("pass_held", int'(pass), 1);

        // res_b stuck at 0: odd-parity vectors 1,2,4,7 fail
        go(1, 4'd4, 3'b001, 1'b1, 1'b0);
        wait_empty();

        // res_a inverted: every vector fails
        go(2, 4'd8, 3'b000, 1'b1, 1'b0);
        wait_empty();

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_errcnt_kept", int'(ec), 8);

        // Abort while vec_out=3 is in WAIT
        go(0, 4'd0, 3'd0, 1'b0, 1'b1);
        wait_vec(3'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(q.pop_back());
        chk("abort_busy", int'(busy), 0);
        chk("abort_vec", int'(vec), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        repeat (20) @(negedge clk);
        go(0, 4'd0, 3'd0, 1'b0, 1'b1);
        wait_empty();

        // Asynchronous reset mid-sweep at vec_out=5, checked between clock edges
        go(1, 4'd4, 3'b001, 1'b1, 1'b0);
        wait_vec(3'd5);
        chk("pre_reset_errcnt", int'(ec), 3);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Restart, with a start pulse mid-sweep that must be ignored
        go(0, 4'd0, 3'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (20) @(negedge clk);

        // SETTLE=3 instance: each vector held four cycles, done after 32
        @(negedge clk);
        start3 = 1'b1;
        q3.push_back('{cyc + 33, 4'd0, 3'd0, 1'b0, 1'b1});
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("vec3_step", int'(vec3), k / 4);
            @(negedge clk);
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/xor_sweep_ctrl.md
Name: xor_sweep_ctrl

Overview:
Self-checking sweep controller for the XOR comparison datapath (3-input behavioural XOR vs. instanced-gate XOR). On `start` it drives every input combination onto the datapath. For each vector it waits a settle time, then samples both implementation outputs and checks them against a golden reduction-XOR. It reports mismatch count, the first failing vector and a pass flag. It sits between a test/config master and the combinational XOR pair, replacing hand-written stimulus sequencing.

Parameters:
N_IN, 3, number of XOR inputs; vector width; sweep length is 2^N_IN (N_IN >= 1)
SETTLE, 1, cycles vec_out is held before sampling (SETTLE >= 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any busy state
res_a  input  1  output of implementation A (behavioural N-input XOR)
res_b  input  1  output of implementation B (instanced XOR)
vec_out  output  N_IN  registered stimulus vector to both implementations
busy  output  1  high from the cycle after start is accepted until FIN
done  output  1  single-cycle pulse at sweep completion
pass  output  1  high after a completed sweep with zero mismatches; held until next start
err_cnt  output  N_IN+1  mismatch count for current/last sweep, saturates at 2^N_IN
first_err_vec  output  N_IN  vector of the first mismatch in the sweep
first_err_valid  output  1  first_err_vec holds a captured value

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid. Internal wait counter = 0. Applies immediately, including mid-sweep.
- States: IDLE, WAIT, CHECK, FIN.
- IDLE, start=1: clear err_cnt, first_err_valid and pass; vec_out<=0; wait_cnt<=SETTLE-1; busy<=1; go to WAIT. start=0: hold.
- WAIT: vec_out stable. If wait_cnt==0, go to CHECK; else decrement.
- CHECK (one cycle):
  - golden = reduction XOR of vec_out.
  - mismatch = (res_a != golden) | (res_b != golden).
  - On mismatch: err_cnt+1, saturating. If first_err_valid=0, capture first_err_vec<=vec_out and set first_err_valid.
  - If vec_out == all-ones: go to FIN. Otherwise vec_out+1, reload wait_cnt<=SETTLE-1, go to WAIT.
- FIN (one cycle): done=1, busy=0, pass=(err_cnt==0). err_cnt already includes the last CHECK. Go to IDLE.
- Latency: done is high exactly 2^N_IN*(SETTLE+1) cycles after the edge that samples start. Default N_IN=3, SETTLE=1 gives 16 cycles.
- Each vector occupies SETTLE+1 cycles; vec_out changes only on the WAIT-entry edge.
- start while busy: ignored, no restart. start=1 in the cycle FIN returns to IDLE: not accepted; it is accepted on the next IDLE cycle if still high.
- abort=1 in WAIT/CHECK/FIN: next state IDLE. busy<=0, done not pulsed, pass<=0, vec_out<=0. err_cnt and first_err_* keep partial results. abort has priority over CHECK updates in the same cycle. abort in IDLE has no effect. start and abort both high in IDLE: abort wins, no start.
- Wrap-around: vec_out never wraps; the sweep ends at all-ones.
- err_cnt saturation: unreachable with N_IN+1 bits (max 2^N_IN), but the guard is required.

Test Plan:
- Correct datapath (res_a=res_b=^vec_out), N_IN=3, SETTLE=1, pulse start -> vec_out steps 0..7, each held 2 cycles; done pulses 16 cycles after start; pass=1, err_cnt=0, first_err_valid=0.
- res_b stuck at 0, res_a correct -> err_cnt=4 (vectors 1,2,4,7); first_err_vec=3'b001; pass=0; done at cycle 16.
- res_a inverted (~^vec) -> err_cnt=8, first_err_vec=3'b000, pass=0.
- abort asserted while vec_out=3 in WAIT -> next cycle IDLE, busy=0, vec_out=0, no done pulse, pass=0. Re-issue start -> full clean sweep, pass=1.
- rst_n low while vec_out=5 -> all outputs 0 immediately, without a clock edge. After release, start works normally. start pulsed again mid-sweep -> ignored, done still at cycle 16.
- SETTLE=3, correct datapath -> each vector held 4 cycles; done 32 cycles after start; pass=1.
